// File: rtl/serial_add_seq.sv
// Bit-serial adder/subtractor: one full adder processes the operands LSB
// first, one bit per clock, WIDTH cycles per operation.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op_sub,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         sum,
  output logic                     cout,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  part_q;
  logic [WIDTH-1:0]  part_d;
  logic [WIDTH-1:0]  sum_q;
  logic              carry_q;
  logic              cout_q;
  logic [CW-1:0]     cnt_q;

  logic ha1_s;
  logic ha1_c;
  logic ha2_c;
  logic fa_s;
  logic fa_c;

  // Single full adder built from two half adders and an OR on the LSBs.
  always_comb begin
    ha1_s  = a_q[0] ^ b_q[0];
    ha1_c  = a_q[0] & b_q[0];
    fa_s   = ha1_s ^ carry_q;
    ha2_c  = ha1_s & carry_q;
    fa_c   = ha1_c | ha2_c;
    part_d = {fa_s, part_q[WIDTH-1:1]};
  end

  // Control FSM plus datapath shift registers; subtraction is a + ~b + 1,
  // so B is inverted at load and the carry is seeded with op_sub.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub;
            cnt_q   <= '0;
            state_q <= RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_c;
          part_q  <= part_d;
          if (cnt_q == LAST_BIT) begin
            cnt_q   <= '0;
            sum_q   <= part_d;
            cout_q  <= fa_c;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
  assign bit_idx = cnt_q;

endmodule
